lane_arbiter: RTL and testbench
===============================

LANE_ARBITER -- requirements
Module: lane_arbiter

Interface
REQ-001 Parameter DATA_W, default 8, byte width of each lane and of the output.
REQ-002 Parameter LANES, fixed at 4, number of requesting lanes.
REQ-003 Port clk_4f, input, 1, sole clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1, synchronous active-low reset, sampled on clk_4f rising edge only.
REQ-005 Port init, input, 1, request to (re)enter INIT and stop granting.
REQ-006 Port fifo_empty, input, 4, per-lane empty flags from show-ahead FIFOs.
REQ-007 Ports fifo_data0..fifo_data3, input, DATA_W each, lane head data, valid whenever the matching empty bit is 0.
REQ-008 Port fifo_error, input, 4, per-lane overflow/underflow flags.
REQ-009 Port out_almost_full, input, 1, downstream backpressure.
REQ-010 Port pop, output, 4, one-hot or zero pop strobe to the lane FIFOs, combinational in the grant cycle.
REQ-011 Port data_out, output, DATA_W, registered granted byte.
REQ-012 Port valid_out, output, 1, registered qualifier for data_out.
REQ-013 Port lane_out, output, 2, registered index of the lane that supplied data_out.
REQ-014 Port state, output, 3, registered FSM state code.
REQ-015 Port xfer_count, output, 16, registered count of granted bytes.
REQ-016 Port error_out, output, 1, registered sticky error flag.

Function
REQ-017 State codes SHALL be RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4.
REQ-018 RESET -> INIT on the first edge with reset high.
REQ-019 INIT -> IDLE on an edge with init low; INIT stays while init is high.
REQ-020 IDLE -> ACTIVE on an edge with any fifo_empty bit 0 and init low.
REQ-021 ACTIVE -> IDLE on an edge with all fifo_empty bits 1.
REQ-022 IDLE or ACTIVE -> INIT on an edge with init high; round-robin pointer cleared to 0.
REQ-023 Any non-RESET state -> ERROR on an edge with any fifo_error bit 1; error takes priority over init; ERROR exits only via reset.
REQ-024 Grants SHALL occur only in ACTIVE, at most one lane per cycle, and only with out_almost_full low.
REQ-025 Grant order: round-robin, search starting at pointer, skipping empty lanes; after a grant, pointer = granted lane + 1 mod 4.
REQ-026 No grant leaves the pointer unchanged.
REQ-027 Pop is asserted in the same cycle as the grant; data_out/lane_out/valid_out reflect it one cycle later (latency 1).
REQ-028 Cycles without a grant SHALL drive valid_out 0 next cycle; data_out and lane_out hold their last values.
REQ-029 out_almost_full high in ACTIVE: pop 0, state stays ACTIVE.
REQ-030 xfer_count increments by 1 per grant and wraps 0xFFFF -> 0x0000; it is cleared only by reset.
REQ-031 error_out SHALL be 1 exactly while state is ERROR.
REQ-032 Transition and grant decisions in a cycle use that cycle's inputs only; no grant is issued in the cycle ACTIVE is entered from IDLE.

Reset
REQ-033 With reset low at an edge: state=RESET, pop=0, data_out=0, valid_out=0, lane_out=0, xfer_count=0, error_out=0, pointer=0.
REQ-034 Reset asserted mid-transfer SHALL discard any in-flight grant; pop SHALL be 0 whenever reset is low.

Structure
REQ-035 State codes and LANES SHALL live in a shared package (lane_pkg) reused by the TX mux and RX demux controllers.
REQ-036 The round-robin priority picker SHALL be one sub-module, rr_picker (request[3:0], pointer[1:0] -> grant[3:0]), purely combinational.

Verification
REQ-037 reset low 2 cycles, then high, init high 3 cycles, then low -> state 0,1,1,1,2; all outputs 0.
REQ-038 All lanes non-empty with bytes 0xA0..0xA3, no backpressure -> pop 0001,0010,0100,1000 repeating; lane_out 0,1,2,3; valid_out 1 each cycle after the first.
REQ-039 Only lanes 1 and 3 non-empty -> pop alternates 0010/1000; lanes 0 and 2 are never popped.
REQ-040 out_almost_full high 3 cycles mid-stream -> pop 0 for 3 cycles, valid_out 0 lagging by one cycle, the next grant resumes at the held pointer.
REQ-041 fifo_error[2]=1 in ACTIVE with init simultaneously high -> state 4, error_out 1, pop 0; state stays 4 until reset.
REQ-042 xfer_count preloaded by 65535 grants, one more grant -> xfer_count 0x0000.

Source files
------------

// File: rtl/lane_pkg.sv
// Shared definitions for the lane arbiter family (TX mux / RX demux controllers):
// lane count, index widths, FSM state codes and a one-hot to index helper.
package lane_pkg;

    localparam int unsigned LANES   = 4;
    localparam int unsigned LANE_W  = 2;
    localparam int unsigned STATE_W = 3;
    localparam int unsigned COUNT_W = 16;

    typedef enum logic [STATE_W-1:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    // Index of the set bit in a one-hot lane vector (0 when the vector is empty).
    function automatic logic [LANE_W-1:0] onehot_to_idx(input logic [LANES-1:0] onehot);
        logic [LANE_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (onehot[i]) begin
                idx = LANE_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin priority picker, purely combinational.
//   request : per-lane request bits
//   pointer : lane with highest priority this cycle
//   grant   : one-hot (or zero) grant, first requester at or after pointer
module rr_picker
    import lane_pkg::*;
(
    input  logic [LANES-1:0]  request,
    input  logic [LANE_W-1:0] pointer,
    output logic [LANES-1:0]  grant
);

    logic [LANE_W-1:0] idx;
    logic              found;

    // Walk the lanes starting at the pointer; the 2-bit index wraps naturally.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            idx = pointer + LANE_W'(i);
            if (!found && request[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lane_arbiter.sv
// Four-lane round-robin byte arbiter draining show-ahead FIFOs into one stream.
//   clk_4f, reset (sync, active-low)
//   init             : return to INIT and stop granting
//   fifo_empty/error : per-lane status; fifo_data0..3 lane head bytes
//   out_almost_full  : downstream backpressure, blocks grants
//   pop              : combinational one-hot pop in the grant cycle
//   data_out/lane_out/valid_out : registered granted byte, one cycle after pop
//   state, xfer_count, error_out : registered status
module lane_arbiter #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LANES  = lane_pkg::LANES
) (
    input  logic                          clk_4f,
    input  logic                          reset,
    input  logic                          init,
    input  logic [LANES-1:0]              fifo_empty,
    input  logic [DATA_W-1:0]             fifo_data0,
    input  logic [DATA_W-1:0]             fifo_data1,
    input  logic [DATA_W-1:0]             fifo_data2,
    input  logic [DATA_W-1:0]             fifo_data3,
    input  logic [LANES-1:0]              fifo_error,
    input  logic                          out_almost_full,
    output logic [LANES-1:0]              pop,
    output logic [DATA_W-1:0]             data_out,
    output logic                          valid_out,
    output logic [lane_pkg::LANE_W-1:0]   lane_out,
    output logic [lane_pkg::STATE_W-1:0]  state,
    output logic [lane_pkg::COUNT_W-1:0]  xfer_count,
    output logic                          error_out
);

    import lane_pkg::*;

    state_t              state_q, state_d;
    logic [LANE_W-1:0]   ptr_q, ptr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic                valid_q, valid_d;
    logic [COUNT_W-1:0]  count_q, count_d;
    logic                error_q, error_d;

    logic [LANES-1:0]    request;
    logic [LANES-1:0]    grant;
    logic [LANE_W-1:0]   grant_idx;
    logic                grant_en;
    logic                any_err;
    logic [DATA_W-1:0]   lane_data [LANES];

    assign lane_data[0] = fifo_data0;
    assign lane_data[1] = fifo_data1;
    assign lane_data[2] = fifo_data2;
    assign lane_data[3] = fifo_data3;

    assign request   = ~fifo_empty;
    assign any_err   = |fifo_error;
    assign grant_idx = onehot_to_idx(grant);

    // Grant only in a steady ACTIVE cycle: leaving ACTIVE (init/error) or
    // backpressure suppresses it, and reset low forces pop to zero.
    assign grant_en = reset && (state_q == ST_ACTIVE) && !init && !any_err
                      && !out_almost_full;

    rr_picker u_picker (
        .request (request),
        .pointer (ptr_q),
        .grant   (grant)
    );

    // State register.
    always_ff @(posedge clk_4f) begin
        if (!reset) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; error outranks init, ERROR is left only through reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET: state_d = ST_INIT;
            ST_INIT: begin
                if (any_err)    state_d = ST_ERROR;
                else if (!init) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (any_err)         state_d = ST_ERROR;
                else if (init)       state_d = ST_INIT;
                else if (|request)   state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (any_err)         state_d = ST_ERROR;
                else if (init)       state_d = ST_INIT;
                else if (&fifo_empty) state_d = ST_IDLE;
            end
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_RESET;
        endcase
    end

    // Output logic: pop strobe and next values of the registered outputs.
    always_comb begin
        pop     = '0;
        data_d  = data_q;
        lane_d  = lane_q;
        valid_d = 1'b0;
        count_d = count_q;
        ptr_d   = ptr_q;
        error_d = (state_d == ST_ERROR);

        if (grant_en) begin
            pop = grant;
        end

        if (|pop) begin
            data_d  = lane_data[grant_idx];
            lane_d  = grant_idx;
            valid_d = 1'b1;
            count_d = count_q + COUNT_W'(1);
            ptr_d   = grant_idx + LANE_W'(1);
        end

        if (state_d == ST_INIT) begin
            ptr_d = '0;
        end
    end

    // Output and pointer registers.
    always_ff @(posedge clk_4f) begin
        if (!reset) begin
            ptr_q   <= '0;
            data_q  <= '0;
            lane_q  <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
            error_q <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            lane_q  <= lane_d;
            valid_q <= valid_d;
            count_q <= count_d;
            error_q <= error_d;
        end
    end

    assign state      = state_q;
    assign data_out   = data_q;
    assign lane_out   = lane_q;
    assign valid_out  = valid_q;
    assign xfer_count = count_q;
    assign error_out  = error_q;

endmodule

// File: tb/tb_lane_arbiter.sv
// Directed testbench for lane_arbiter with hand-computed expectations.
module tb_lane_arbiter;

    logic        clk_4f = 1'b0;
    logic        reset;
    logic        init;
    logic [3:0]  fifo_empty;
    logic [7:0]  fifo_data0, fifo_data1, fifo_data2, fifo_data3;
    logic [3:0]  fifo_error;
    logic        out_almost_full;
    logic [3:0]  pop;
    logic [7:0]  data_out;
    logic        valid_out;
    logic [1:0]  lane_out;
    logic [2:0]  state;
    logic [15:0] xfer_count;
    logic        error_out;

    int n_tests = 0;
    int n_fail  = 0;

    lane_arbiter #(.DATA_W(8), .LANES(4)) dut (
        .clk_4f          (clk_4f),
        .reset           (reset),
        .init            (init),
        .fifo_empty      (fifo_empty),
        .fifo_data0      (fifo_data0),
        .fifo_data1      (fifo_data1),
        .fifo_data2      (fifo_data2),
        .fifo_data3      (fifo_data3),
        .fifo_error      (fifo_error),
        .out_almost_full (out_almost_full),
        .pop             (pop),
        .data_out        (data_out),
        .valid_out       (valid_out),
        .lane_out        (lane_out),
        .state           (state),
        .xfer_count      (xfer_count),
        .error_out       (error_out)
    );

    always #5 clk_4f = ~clk_4f;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past one rising edge; registered outputs are stable afterwards.
    task automatic tick();
        @(posedge clk_4f);
        #1;
    endtask

    // Check the registered byte-stream outputs together.
    task automatic check_out(input string tag, input logic v, input logic [7:0] d,
                             input logic [1:0] l, input logic [15:0] cnt);
        check({tag, ".valid"}, 32'(valid_out), 32'(v));
        check({tag, ".data"},  32'(data_out),  32'(d));
        check({tag, ".lane"},  32'(lane_out),  32'(l));
        check({tag, ".count"}, 32'(xfer_count), 32'(cnt));
    endtask

    initial begin
        logic [3:0] exp_pop;

        reset = 1'b0; init = 1'b1; fifo_empty = 4'hF; fifo_error = 4'h0;
        out_almost_full = 1'b0;
        fifo_data0 = 8'hA0; fifo_data1 = 8'hA1; fifo_data2 = 8'hA2; fifo_data3 = 8'hA3;

        // Reset sequence: states 0,0 then 1,1,1 while init high, then 2.
        tick();
        check("rst0.state", 32'(state), 32'd0);
        check("rst0.pop",   32'(pop),   32'd0);
        check("rst0.err",   32'(error_out), 32'd0);
        check_out("rst0", 1'b0, 8'h00, 2'd0, 16'd0);
        tick();
        check("rst1.state", 32'(state), 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("init.state", 32'(state), 32'd1);
        end
        init = 1'b0;
        tick();
        check("idle.state", 32'(state), 32'd2);
        check_out("idle", 1'b0, 8'h00, 2'd0, 16'd0);

        // All lanes non-empty: no grant on ACTIVE entry, then 0,1,2,3 repeating.
        fifo_empty = 4'h0;
        #1 check("idle.pop", 32'(pop), 32'd0);
        tick();
        check("enter.state", 32'(state), 32'd3);
        check("enter.valid", 32'(valid_out), 32'd0);
        for (int k = 0; k < 8; k++) begin
            exp_pop = 4'b0001 << (k % 4);
            #1 check("rr.pop", 32'(pop), 32'(exp_pop));
            tick();
            check_out("rr", 1'b1, 8'(8'hA0 + 8'(k % 4)), 2'(k % 4), 16'(k + 1));
        end

        // Backpressure: one grant from lane 0, then 3 stalled cycles.
        #1 check("pre_bp.pop", 32'(pop), 32'b0001);
        tick();
        check_out("pre_bp", 1'b1, 8'hA0, 2'd0, 16'd9);
        out_almost_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 check("bp.pop", 32'(pop), 32'd0);
            tick();
            check("bp.state", 32'(state), 32'd3);
            check_out("bp", 1'b0, 8'hA0, 2'd0, 16'd9);
        end
        out_almost_full = 1'b0;
        #1 check("resume.pop", 32'(pop), 32'b0010);
        tick();
        check_out("resume", 1'b1, 8'hA1, 2'd1, 16'd10);

        // Only lanes 1 and 3: pointer is 2, so 3,1,3,1.
        fifo_empty = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            exp_pop = (k % 2 == 0) ? 4'b1000 : 4'b0010;
            #1 check("odd.pop", 32'(pop), 32'(exp_pop));
            check("odd.no02", 32'(pop & 4'b0101), 32'd0);
            tick();
            check_out("odd", 1'b1, (k % 2 == 0) ? 8'hA3 : 8'hA1,
                      (k % 2 == 0) ? 2'd3 : 2'd1, 16'(11 + k));
        end

        // All empty: back to IDLE, outputs hold, valid drops.
        fifo_empty = 4'hF;
        #1 check("drain.pop", 32'(pop), 32'd0);
        tick();
        check("drain.state", 32'(state), 32'd2);
        check_out("drain", 1'b0, 8'hA1, 2'd1, 16'd14);

        // init from IDLE clears the pointer (was 2): next grant is lane 0.
        init = 1'b1;
        tick();
        check("reinit.state", 32'(state), 32'd1);
        init = 1'b0;
        fifo_empty = 4'h0;
        tick();
        check("reidle.state", 32'(state), 32'd2);
        tick();
        check("react.state", 32'(state), 32'd3);
        #1 check("react.pop", 32'(pop), 32'b0001);

        // Error with init simultaneously high: error wins, no pop, sticky.
        fifo_error = 4'b0100;
        init = 1'b1;
        #1 check("err.pop", 32'(pop), 32'd0);
        tick();
        check("err.state", 32'(state), 32'd4);
        check("err.flag",  32'(error_out), 32'd1);
        check_out("err", 1'b0, 8'hA1, 2'd1, 16'd14);
        fifo_error = 4'h0;
        init = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1 check("errhold.pop", 32'(pop), 32'd0);
            tick();
            check("errhold.state", 32'(state), 32'd4);
            check("errhold.flag",  32'(error_out), 32'd1);
        end
        reset = 1'b0;
        tick();
        check("errrst.state", 32'(state), 32'd0);
        check("errrst.flag",  32'(error_out), 32'd0);
        check_out("errrst", 1'b0, 8'h00, 2'd0, 16'd0);

        // Counter wrap: 65535 grants, then one more wraps to zero.
        reset = 1'b1;
        tick();
        check("wrap.init", 32'(state), 32'd1);
        tick();
        check("wrap.idle", 32'(state), 32'd2);
        tick();
        check("wrap.active", 32'(state), 32'd3);
        for (int i = 0; i < 65535; i++) begin
            tick();
        end
        check("wrap.ffff", 32'(xfer_count), 32'hFFFF);
        tick();
        check("wrap.zero", 32'(xfer_count), 32'h0000);
        check("wrap.valid", 32'(valid_out), 32'd1);
        #1 check("wrap.pop", 32'(pop), 32'b0001);

        // Reset mid-transfer drops the pending grant immediately.
        reset = 1'b0;
        #1 check("midrst.pop", 32'(pop), 32'd0);
        tick();
        check("midrst.state", 32'(state), 32'd0);
        check_out("midrst", 1'b0, 8'h00, 2'd0, 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
